scariv_fpu_wb_arb: RTL and testbench

//  Write-back arbiter after the FPU pipe. Merges the fixed-latency move result (ex3 mv) and the

---
 rtl/scariv_fpu_wb_arb_if.sv | 44 ++++
 rtl/scariv_fpu_wb_arb.sv | 172 +++++++++++++++++
 tb/tb_scariv_fpu_wb_arb.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scariv_fpu_wb_arb_if.sv
// Result/handshake bundle between the FPU pipe, the FP write-back arbiter and the FP register file.
interface scariv_fpu_wb_arb_if #(
    parameter int RNID_W   = 7,
    parameter int DATA_W   = 64,
    parameter int CMT_ID_W = 7
);
    logic                mv_valid;
    logic [RNID_W-1:0]   mv_rd;
    logic [DATA_W-1:0]   mv_data;
    logic [CMT_ID_W-1:0] mv_cmt_id;

    logic                fp_valid;
    logic                fp_ready;
    logic [RNID_W-1:0]   fp_rd;
    logic [DATA_W-1:0]   fp_data;
    logic [CMT_ID_W-1:0] fp_cmt_id;
    logic [4:0]          fp_fflags;

    logic                flush_valid;
    logic [CMT_ID_W-1:0] flush_cmt_id;

    logic                wb_valid;
    logic [RNID_W-1:0]   wb_rd;
    logic [DATA_W-1:0]   wb_data;
    logic                done_valid;
    logic [CMT_ID_W-1:0] done_cmt_id;
    logic [4:0]          done_fflags;

    modport slave (
        input  mv_valid, mv_rd, mv_data, mv_cmt_id,
        input  fp_valid, fp_rd, fp_data, fp_cmt_id, fp_fflags,
        output fp_ready,
        input  flush_valid, flush_cmt_id,
        output wb_valid, wb_rd, wb_data, done_valid, done_cmt_id, done_fflags
    );

    modport master (
        output mv_valid, mv_rd, mv_data, mv_cmt_id,
        output fp_valid, fp_rd, fp_data, fp_cmt_id, fp_fflags,
        input  fp_ready,
        output flush_valid, flush_cmt_id,
        input  wb_valid, wb_rd, wb_data, done_valid, done_cmt_id, done_fflags
    );
endinterface

// File: rtl/scariv_fpu_wb_arb.sv
// FP write-back arbiter: mv result beats FPnew, losing FPnew results wait in an in-order FIFO.
// Optional perf counters are enabled with the macro SCARIV_FPU_WB_PERF_EN.
module scariv_fpu_wb_arb #(
    parameter int RNID_W     = 7,
    parameter int DATA_W     = 64,
    parameter int CMT_ID_W   = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
`ifdef SCARIV_FPU_WB_PERF_EN
    output logic [31:0]        o_perf_fp_stall,
    output logic [31:0]        o_perf_conflict,
`endif
    scariv_fpu_wb_arb_if.slave bus
);
    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    // x is younger than f when the wrapped distance lies in the lower half of the id space
    function automatic logic is_younger(input logic [CMT_ID_W-1:0] x, input logic [CMT_ID_W-1:0] f);
        logic [CMT_ID_W-1:0] diff;
        diff = x - f;
        return (diff != '0) && !diff[CMT_ID_W-1];
    endfunction

    logic [FIFO_DEPTH-1:0] ent_vld;
    logic [RNID_W-1:0]     ent_rd     [FIFO_DEPTH];
    logic [DATA_W-1:0]     ent_data   [FIFO_DEPTH];
    logic [CMT_ID_W-1:0]   ent_cmt_id [FIFO_DEPTH];
    logic [4:0]            ent_fflags [FIFO_DEPTH];

    logic [PTR_W-1:0] rd_ptr, wr_ptr, occupancy;
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic             fifo_empty, fp_ready;

    assign occupancy  = wr_ptr - rd_ptr;
    assign rd_idx     = rd_ptr[IDX_W-1:0];
    assign wr_idx     = wr_ptr[IDX_W-1:0];
    assign fifo_empty = (occupancy == '0);
    assign fp_ready   = (occupancy < PTR_W'(FIFO_DEPTH));
    assign bus.fp_ready = fp_ready;

    logic                mv_take, fp_take, head_live, pop, bypass, push;
    logic                sel_vld;
    logic [RNID_W-1:0]   sel_rd;
    logic [DATA_W-1:0]   sel_data;
    logic [CMT_ID_W-1:0] sel_cmt_id;
    logic [4:0]          sel_fflags;

    // Stage p0: flush filtering and source selection
    always_comb begin
        mv_take   = bus.mv_valid &&
                    !(bus.flush_valid && is_younger(bus.mv_cmt_id, bus.flush_cmt_id));
        fp_take   = bus.fp_valid && fp_ready &&
                    !(bus.flush_valid && is_younger(bus.fp_cmt_id, bus.flush_cmt_id));
        head_live = ent_vld[rd_idx] &&
                    !(bus.flush_valid && is_younger(ent_cmt_id[rd_idx], bus.flush_cmt_id));
        pop       = !mv_take && !fifo_empty;
        bypass    = !mv_take && fifo_empty && fp_take;
        push      = fp_take && !bypass;

        sel_vld    = 1'b0;
        sel_rd     = bus.mv_rd;
        sel_data   = bus.mv_data;
        sel_cmt_id = bus.mv_cmt_id;
        sel_fflags = 5'd0;
        if (mv_take) begin
            sel_vld = 1'b1;
        end else if (pop) begin
            sel_vld    = head_live;
            sel_rd     = ent_rd[rd_idx];
            sel_data   = ent_data[rd_idx];
            sel_cmt_id = ent_cmt_id[rd_idx];
            sel_fflags = ent_fflags[rd_idx];
        end else if (bypass) begin
            sel_vld    = 1'b1;
            sel_rd     = bus.fp_rd;
            sel_data   = bus.fp_data;
            sel_cmt_id = bus.fp_cmt_id;
            sel_fflags = bus.fp_fflags;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            ent_vld <= '0;
        end else begin
            // flushed entries stay in place and are skipped when they reach the head
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (bus.flush_valid && is_younger(ent_cmt_id[i], bus.flush_cmt_id)) begin
                    ent_vld[i] <= 1'b0;
                end
            end
            if (pop) begin
                ent_vld[rd_idx] <= 1'b0;
                rd_ptr          <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                ent_vld[wr_idx] <= 1'b1;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            ent_rd[wr_idx]     <= bus.fp_rd;
            ent_data[wr_idx]   <= bus.fp_data;
            ent_cmt_id[wr_idx] <= bus.fp_cmt_id;
            ent_fflags[wr_idx] <= bus.fp_fflags;
        end
    end

    // Stage p1: registered write-back / done report
    logic                wb_vld_p1;
    logic [RNID_W-1:0]   wb_rd_p1;
    logic [DATA_W-1:0]   wb_data_p1;
    logic [CMT_ID_W-1:0] done_cmt_id_p1;
    logic [4:0]          done_fflags_p1;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wb_vld_p1      <= 1'b0;
            wb_rd_p1       <= '0;
            wb_data_p1     <= '0;
            done_cmt_id_p1 <= '0;
            done_fflags_p1 <= '0;
        end else begin
            wb_vld_p1 <= sel_vld;
            if (sel_vld) begin
                wb_rd_p1       <= sel_rd;
                wb_data_p1     <= sel_data;
                done_cmt_id_p1 <= sel_cmt_id;
                done_fflags_p1 <= sel_fflags;
            end
        end
    end

    assign bus.wb_valid    = wb_vld_p1;
    assign bus.wb_rd       = wb_rd_p1;
    assign bus.wb_data     = wb_data_p1;
    assign bus.done_valid  = wb_vld_p1;
    assign bus.done_cmt_id = done_cmt_id_p1;
    assign bus.done_fflags = done_fflags_p1;

`ifdef SCARIV_FPU_WB_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_perf_fp_stall <= '0;
            o_perf_conflict <= '0;
        end else begin
            if (bus.fp_valid && !fp_ready) begin
                o_perf_fp_stall <= sat_inc(o_perf_fp_stall);
            end
            if (bus.mv_valid && (!fifo_empty || bus.fp_valid)) begin
                o_perf_conflict <= sat_inc(o_perf_conflict);
            end
        end
    end
`endif

    a_fp_ready_proto: assert property (@(posedge i_clk) disable iff (i_reset)
        bus.fp_valid |-> fp_ready);

endmodule

// File: tb/tb_scariv_fpu_wb_arb.sv
// Randomised and directed bench for scariv_fpu_wb_arb against a queue-based reference model.
module tb_scariv_fpu_wb_arb;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scariv_fpu_wb_arb_if #(.RNID_W(7), .DATA_W(64), .CMT_ID_W(7)) bus ();

    scariv_fpu_wb_arb #(.RNID_W(7), .DATA_W(64), .CMT_ID_W(7), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic        vld;
        logic [6:0]  rd;
        logic [63:0] data;
        logic [6:0]  id;
        logic [4:0]  ff;
    } ent_t;

    ent_t        q[$];
    logic        exp_v;
    logic [6:0]  exp_rd;
    logic [63:0] exp_data;
    logic [6:0]  exp_id;
    logic [4:0]  exp_ff;
    int n_checks = 0;
    int n_fail   = 0;

    function automatic bit tb_younger(int x, int f);
        int d;
        d = (((x - f) % 128) + 128) % 128;
        return (d >= 1) && (d < 64);
    endfunction

    function automatic bit m_ready();
        return q.size() < DEPTH;
    endfunction

    function automatic logic [84:0] obs();
        return {bus.wb_valid, bus.done_valid, bus.wb_rd, bus.wb_data, bus.done_cmt_id, bus.done_fflags};
    endfunction

    function automatic logic [84:0] expv();
        return {exp_v, exp_v, exp_rd, exp_data, exp_id, exp_ff};
    endfunction

    task automatic set_idle();
        bus.mv_valid = 0; bus.mv_rd = 0; bus.mv_data = 0; bus.mv_cmt_id = 0;
        bus.fp_valid = 0; bus.fp_rd = 0; bus.fp_data = 0; bus.fp_cmt_id = 0; bus.fp_fflags = 0;
        bus.flush_valid = 0; bus.flush_cmt_id = 0;
    endtask

    task automatic drive_mv(input logic [6:0] rd, input logic [63:0] data, input logic [6:0] id);
        bus.mv_valid = 1; bus.mv_rd = rd; bus.mv_data = data; bus.mv_cmt_id = id;
    endtask

    task automatic drive_fp(input logic [6:0] rd, input logic [63:0] data, input logic [6:0] id,
                            input logic [4:0] ff);
        bus.fp_valid = 1; bus.fp_rd = rd; bus.fp_data = data; bus.fp_cmt_id = id; bus.fp_fflags = ff;
    endtask

    // Advance the reference model by one clock using the inputs currently driven, then the clock.
    task automatic step();
        ent_t fpe, o, e;
        bit   ov, mvok, fpok;
        if (rst) begin
            q.delete();
            exp_v = 0; exp_rd = 0; exp_data = 0; exp_id = 0; exp_ff = 0;
        end else begin
            fpe  = '{1'b1, bus.fp_rd, bus.fp_data, bus.fp_cmt_id, bus.fp_fflags};
            mvok = bus.mv_valid && !(bus.flush_valid && tb_younger(bus.mv_cmt_id, bus.flush_cmt_id));
            fpok = bus.fp_valid && m_ready() &&
                   !(bus.flush_valid && tb_younger(bus.fp_cmt_id, bus.flush_cmt_id));
            if (bus.flush_valid)
                foreach (q[i]) if (tb_younger(q[i].id, bus.flush_cmt_id)) q[i].vld = 1'b0;
            ov = 0;
            o  = '0;
            if (mvok) begin
                ov = 1; o = '{1'b1, bus.mv_rd, bus.mv_data, bus.mv_cmt_id, 5'd0};
            end else if (q.size() != 0) begin
                e = q.pop_front();
                if (e.vld) begin ov = 1; o = e; end
            end else if (fpok) begin
                ov = 1; o = fpe; fpok = 0;
            end
            if (fpok) q.push_back(fpe);
            exp_v = ov;
            if (ov) begin exp_rd = o.rd; exp_data = o.data; exp_id = o.id; exp_ff = o.ff; end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; set_idle();
        step(); step();
        n_checks++;
        if (obs() !== 85'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", obs()); end
        n_checks++;
        if (bus.fp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.fp_ready); end
        rst = 0;
        step();
    endtask

    task automatic test_mv_only();
        drive_mv(7'd5, 64'h3FF0_0000_0000_0000, 7'd3);
        step();
        set_idle();
        n_checks++;
        if (obs() !== expv()) begin n_fail++; $display("FAIL mv_only: got %h want %h", obs(), expv()); end
        n_checks++;
        if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.done_cmt_id, bus.done_fflags} !==
            {1'b1, 7'd5, 64'h3FF0_0000_0000_0000, 7'd3, 5'd0}) begin
            n_fail++; $display("FAIL mv_only_const: got rd=%0d data=%h id=%0d", bus.wb_rd, bus.wb_data, bus.done_cmt_id);
        end
        step();
        n_checks++;
        if (obs() !== expv()) begin n_fail++; $display("FAIL mv_only_hold: got %h want %h", obs(), expv()); end
    endtask

    task automatic test_conflict();
        drive_mv(7'd1, 64'h1111, 7'd20);
        drive_fp(7'd2, 64'h2222, 7'd21, 5'h01);
        for (int c = 0; c < 3; c++) begin
            step();
            set_idle();
            n_checks++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL conflict c%0d: got %h want %h", c, obs(), expv()); end
            if (c == 1) begin
                n_checks++;
                if ({bus.wb_valid, bus.wb_rd, bus.done_fflags} !== {1'b1, 7'd2, 5'h01}) begin
                    n_fail++; $display("FAIL conflict_fp_second: got rd=%0d ff=%h", bus.wb_rd, bus.done_fflags);
                end
            end
        end
    endtask

    task automatic test_full();
        for (int c = 0; c < 6; c++) begin
            set_idle();
            drive_mv(7'(20 + c), 64'(c), 7'd30);
            if (m_ready()) drive_fp(7'(40 + c), 64'(100 + c), 7'(31 + c), 5'(c));
            step();
            n_checks++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL full_fill c%0d: got %h want %h", c, obs(), expv()); end
            n_checks++;
            if (bus.fp_ready !== m_ready()) begin n_fail++; $display("FAIL full_ready c%0d: got %b want %b", c, bus.fp_ready, m_ready()); end
        end
        set_idle();
        for (int c = 0; c < 5; c++) begin
            step();
            n_checks++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL full_drain c%0d: got %h want %h", c, obs(), expv()); end
            if (c < 4) begin
                n_checks++;
                if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 7'(40 + c)) begin
                    n_fail++; $display("FAIL full_order c%0d: got v=%b rd=%0d want rd=%0d", c, bus.wb_valid, bus.wb_rd, 40 + c);
                end
            end
        end
    endtask

    task automatic flush_scenario(input string nm, input int ids[], input int fid);
        int n_wr;
        foreach (ids[k]) begin
            set_idle();
            drive_mv(7'd1, 64'hAA, 7'd100);
            drive_fp(7'(10 + k), 64'(ids[k]), 7'(ids[k]), 5'd0);
            step();
            n_checks++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL %s_fill k%0d: got %h want %h", nm, k, obs(), expv()); end
        end
        set_idle();
        bus.flush_valid = 1; bus.flush_cmt_id = 7'(fid);
        n_wr = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            set_idle();
            n_wr += int'(bus.wb_valid);
            n_checks++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL %s_drain c%0d: got %h want %h", nm, c, obs(), expv()); end
        end
        n_checks++;
        if (n_wr != 2) begin n_fail++; $display("FAIL %s_writes: got %0d want 2", nm, n_wr); end
    endtask

    task automatic test_flush();
        flush_scenario("flush", '{10, 11, 12, 13}, 11);
    endtask

    task automatic test_wrap();
        flush_scenario("wrap", '{126, 127, 0}, 127);
    endtask

    task automatic test_reset_mid();
        int n_wr;
        for (int k = 0; k < 3; k++) begin
            set_idle();
            drive_mv(7'd3, 64'h55, 7'd50);
            drive_fp(7'(60 + k), 64'(k), 7'(51 + k), 5'd2);
            step();
        end
        set_idle();
        #2 rst = 1;
        step();
        rst = 0;
        n_wr = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            n_wr += int'(bus.wb_valid);
            n_checks++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL reset_mid c%0d: got %h want %h", c, obs(), expv()); end
        end
        n_checks++;
        if (n_wr != 0 || bus.fp_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_quiet: got writes=%0d ready=%b want 0/1", n_wr, bus.fp_ready);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            set_idle();
            if ($urandom_range(0, 2) == 0)
                drive_mv(7'($urandom), {$urandom, $urandom}, 7'($urandom));
            if ($urandom_range(0, 1) == 1 && m_ready())
                drive_fp(7'($urandom), {$urandom, $urandom}, 7'($urandom), 5'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                bus.flush_valid = 1; bus.flush_cmt_id = 7'($urandom);
            end
            step();
            n_checks++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL random c%0d: got %h want %h", c, obs(), expv()); end
            n_checks++;
            if (bus.fp_ready !== m_ready()) begin n_fail++; $display("FAIL random_ready c%0d: got %b want %b", c, bus.fp_ready, m_ready()); end
        end
        set_idle();
        for (int c = 0; c < 6; c++) begin
            step();
            n_checks++;
            if (obs() !== expv()) begin n_fail++; $display("FAIL random_drain c%0d: got %h want %h", c, obs(), expv()); end
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_mv_only();
        test_conflict();
        test_full();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
